// File: rtl/hub75_rx_if.sv
// Event bundle produced by the HUB75 receiver: per-pixel writes, per-line latches and
// per-row display on-time measurements.
interface hub75_rx_if #(
    parameter int N_BANKS = 2,
    parameter int N_ROWS  = 32,
    parameter int N_COLS  = 64,
    parameter int N_CHANS = 3,
    parameter int ON_W    = 16
);
    localparam int LOG_N_ROWS = $clog2(N_ROWS);
    localparam int LOG_N_COLS = $clog2(N_COLS);
    localparam int DW         = N_BANKS * N_CHANS;

    logic                  pix_valid;
    logic [LOG_N_COLS-1:0] pix_col;
    logic [DW-1:0]         pix_data;
    logic                  line_valid;
    logic [LOG_N_ROWS-1:0] line_row;
    logic [LOG_N_COLS:0]   line_len;
    logic                  on_valid;
    logic [LOG_N_ROWS-1:0] on_row;
    logic [ON_W-1:0]       on_cycles;

    modport master (
        output pix_valid, pix_col, pix_data,
        output line_valid, line_row, line_len,
        output on_valid, on_row, on_cycles
    );

    modport slave (
        input pix_valid, pix_col, pix_data,
        input line_valid, line_row, line_len,
        input on_valid, on_row, on_cycles
    );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronises the panel pins into the fabric clock domain and rebuilds the
// shift / latch / display activity as single-cycle event pulses with held payloads.
module hub75_rx #(
    parameter int N_BANKS     = 2,
    parameter int N_ROWS      = 32,
    parameter int N_COLS      = 64,
    parameter int N_CHANS     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ON_W        = 16,
    localparam int LOG_N_ROWS = $clog2(N_ROWS),
    localparam int LOG_N_COLS = $clog2(N_COLS),
    localparam int DW         = N_BANKS * N_CHANS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LOG_N_ROWS-1:0] hub75_addr,
    input  logic [DW-1:0]         hub75_data,
    input  logic                  hub75_clk,
    input  logic                  hub75_le,
    input  logic                  hub75_blank,
    hub75_rx_if.master            evt,
    output logic                  err_overflow,
    output logic                  err_addr_chg
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [LOG_N_COLS:0] COL_FULL = (LOG_N_COLS+1)'(N_COLS);
    localparam logic [LOG_N_COLS:0] COL_ONE  = (LOG_N_COLS+1)'(1);
    localparam logic [ON_W-1:0]     ON_MAX   = {ON_W{1'b1}};
    localparam logic [ON_W-1:0]     ON_ONE   = ON_W'(1);

    // Stage SYNC_STAGES-1 is the synchronised value; stage SYNC_STAGES is its one-cycle delay.
    logic [SYNC_STAGES:0][LOG_N_ROWS-1:0] addr_pipe_r;
    logic [SYNC_STAGES-1:0][DW-1:0]       data_pipe_r;
    logic [SYNC_STAGES:0]                 clk_pipe_r;
    logic [SYNC_STAGES:0]                 le_pipe_r;
    logic [SYNC_STAGES:0]                 blank_pipe_r;

    state_t                state_r, state_next_s;
    logic [LOG_N_COLS:0]   col_r, col_next_s, col_after_pix_s;
    logic                  pix_fire_s, line_fire_s, ovf_set_s;

    logic [ON_W-1:0]       on_cnt_r, on_cnt_next_s;
    logic [LOG_N_ROWS-1:0] on_row_cap_r, on_row_cap_next_s;
    logic                  on_fire_s, addr_chg_s;

    logic                  pix_valid_r, line_valid_r, on_valid_r;
    logic [LOG_N_COLS-1:0] pix_col_r;
    logic [DW-1:0]         pix_data_r;
    logic [LOG_N_ROWS-1:0] line_row_r, on_row_r;
    logic [LOG_N_COLS:0]   line_len_r;
    logic [ON_W-1:0]       on_cycles_r;
    logic                  err_overflow_r, err_addr_chg_r;

    logic [LOG_N_ROWS-1:0] addr_s, addr_prev_s;
    logic [DW-1:0]         data_s;
    logic                  clk_rise_s, le_rise_s, blank_low_s, blank_fall_s, blank_rise_s;

    assign addr_s       = addr_pipe_r[SYNC_STAGES-1];
    assign addr_prev_s  = addr_pipe_r[SYNC_STAGES];
    assign data_s       = data_pipe_r[SYNC_STAGES-1];
    assign clk_rise_s   = clk_pipe_r[SYNC_STAGES-1] & ~clk_pipe_r[SYNC_STAGES];
    assign le_rise_s    = le_pipe_r[SYNC_STAGES-1] & ~le_pipe_r[SYNC_STAGES];
    assign blank_low_s  = ~blank_pipe_r[SYNC_STAGES-1];
    assign blank_fall_s = ~blank_pipe_r[SYNC_STAGES-1] & blank_pipe_r[SYNC_STAGES];
    assign blank_rise_s = blank_pipe_r[SYNC_STAGES-1] & ~blank_pipe_r[SYNC_STAGES];

    // Input synchronisers plus edge-detect delay stage; blank idles high so reset is "LEDs off".
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_pipe_r  <= '0;
            data_pipe_r  <= '0;
            clk_pipe_r   <= '0;
            le_pipe_r    <= '0;
            blank_pipe_r <= '1;
        end else begin
            addr_pipe_r  <= {addr_pipe_r[SYNC_STAGES-1:0], hub75_addr};
            data_pipe_r  <= {data_pipe_r[SYNC_STAGES-2:0], hub75_data};
            clk_pipe_r   <= {clk_pipe_r[SYNC_STAGES-1:0], hub75_clk};
            le_pipe_r    <= {le_pipe_r[SYNC_STAGES-1:0], hub75_le};
            blank_pipe_r <= {blank_pipe_r[SYNC_STAGES-1:0], hub75_blank};
        end
    end

    // Shift FSM next state: a pixel on the same cycle as a latch is counted before the clear.
    always_comb begin
        state_next_s    = state_r;
        col_after_pix_s = col_r;
        col_next_s      = col_r;
        pix_fire_s      = 1'b0;
        ovf_set_s       = 1'b0;
        line_fire_s     = 1'b0;
        if (clk_rise_s) begin
            case (state_r)
                ST_IDLE, ST_SHIFT: begin
                    pix_fire_s      = 1'b1;
                    col_after_pix_s = col_r + COL_ONE;
                    if (col_after_pix_s == COL_FULL) begin
                        state_next_s = ST_FULL;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end
                ST_FULL: begin
                    ovf_set_s = 1'b1;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            col_after_pix_s = col_r;
        end
        if (le_rise_s) begin
            line_fire_s  = 1'b1;
            col_next_s   = '0;
            state_next_s = ST_IDLE;
        end else begin
            col_next_s = col_after_pix_s;
        end
    end

    // On-time counter: starts at 1 on the falling edge so the report equals cycles blank was low.
    always_comb begin
        on_cnt_next_s     = on_cnt_r;
        on_row_cap_next_s = on_row_cap_r;
        on_fire_s         = 1'b0;
        addr_chg_s        = 1'b0;
        if (blank_fall_s) begin
            on_cnt_next_s     = ON_ONE;
            on_row_cap_next_s = addr_s;
        end else if (blank_low_s) begin
            addr_chg_s = (addr_s != addr_prev_s);
            if (on_cnt_r != ON_MAX) begin
                on_cnt_next_s = on_cnt_r + ON_ONE;
            end else begin
                on_cnt_next_s = on_cnt_r;
            end
        end else begin
            on_fire_s = blank_rise_s;
        end
    end

    // State, counters, registered event outputs and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            col_r          <= '0;
            on_cnt_r       <= '0;
            on_row_cap_r   <= '0;
            pix_valid_r    <= 1'b0;
            pix_col_r      <= '0;
            pix_data_r     <= '0;
            line_valid_r   <= 1'b0;
            line_row_r     <= '0;
            line_len_r     <= '0;
            on_valid_r     <= 1'b0;
            on_row_r       <= '0;
            on_cycles_r    <= '0;
            err_overflow_r <= 1'b0;
            err_addr_chg_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            col_r        <= col_next_s;
            on_cnt_r     <= on_cnt_next_s;
            on_row_cap_r <= on_row_cap_next_s;
            pix_valid_r  <= pix_fire_s;
            line_valid_r <= line_fire_s;
            on_valid_r   <= on_fire_s;
            if (pix_fire_s) begin
                pix_col_r  <= col_r[LOG_N_COLS-1:0];
                pix_data_r <= data_s;
            end
            if (line_fire_s) begin
                line_row_r <= addr_s;
                line_len_r <= col_after_pix_s;
            end
            if (on_fire_s) begin
                on_row_r    <= on_row_cap_r;
                on_cycles_r <= on_cnt_r;
            end
            err_overflow_r <= err_overflow_r | ovf_set_s;
            err_addr_chg_r <= err_addr_chg_r | addr_chg_s;
        end
    end

    assign evt.pix_valid  = pix_valid_r;
    assign evt.pix_col    = pix_col_r;
    assign evt.pix_data   = pix_data_r;
    assign evt.line_valid = line_valid_r;
    assign evt.line_row   = line_row_r;
    assign evt.line_len   = line_len_r;
    assign evt.on_valid   = on_valid_r;
    assign evt.on_row     = on_row_r;
    assign evt.on_cycles  = on_cycles_r;
    assign err_overflow   = err_overflow_r;
    assign err_addr_chg   = err_addr_chg_r;
endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: two instances share the pins, one with a 4-bit on-time counter
// so saturation can be seen alongside the full-width measurement.
module tb_hub75_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hub75_addr  = 5'd0;
    logic [5:0] hub75_data  = 6'd0;
    logic       hub75_clk   = 1'b0;
    logic       hub75_le    = 1'b0;
    logic       hub75_blank = 1'b1;
    logic       err_ovf_a, err_addr_a, err_ovf_b, err_addr_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int pix_cyc_q[$], pix_col_q[$], pix_dat_q[$];
    int line_cyc_q[$], line_row_q[$], line_len_q[$];
    int on_row_q[$], on_cyc_q[$], onb_row_q[$], onb_cyc_q[$];

    hub75_rx_if #(.ON_W(16)) evt_a ();
    hub75_rx_if #(.ON_W(4))  evt_b ();

    hub75_rx #(.ON_W(16)) dut_a (
        .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
        .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
        .evt(evt_a), .err_overflow(err_ovf_a), .err_addr_chg(err_addr_a)
    );

    hub75_rx #(.ON_W(4)) dut_b (
        .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
        .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
        .evt(evt_b), .err_overflow(err_ovf_b), .err_addr_chg(err_addr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: logs pulses away from the active edge; comparisons happen in the tests.
    always @(negedge clk) begin
        if (evt_a.pix_valid) begin
            pix_cyc_q.push_back(cyc);
            pix_col_q.push_back(int'(evt_a.pix_col));
            pix_dat_q.push_back(int'(evt_a.pix_data));
        end
        if (evt_a.line_valid) begin
            line_cyc_q.push_back(cyc);
            line_row_q.push_back(int'(evt_a.line_row));
            line_len_q.push_back(int'(evt_a.line_len));
        end
        if (evt_a.on_valid) begin
            on_row_q.push_back(int'(evt_a.on_row));
            on_cyc_q.push_back(int'(evt_a.on_cycles));
        end
        if (evt_b.on_valid) begin
            onb_row_q.push_back(int'(evt_b.on_row));
            onb_cyc_q.push_back(int'(evt_b.on_cycles));
        end
    end

    task automatic clear_q();
        pix_cyc_q.delete();  pix_col_q.delete();  pix_dat_q.delete();
        line_cyc_q.delete(); line_row_q.delete(); line_len_q.delete();
        on_row_q.delete();   on_cyc_q.delete();   onb_row_q.delete(); onb_cyc_q.delete();
    endtask

    task automatic shift_pix(input logic [5:0] d);
        @(negedge clk);
        hub75_data = d;
        hub75_clk  = 1'b1;
        repeat (2) @(negedge clk);
        hub75_clk = 1'b0;
        repeat (1) @(negedge clk);
    endtask

    task automatic latch();
        @(negedge clk);
        hub75_le = 1'b1;
        repeat (2) @(negedge clk);
        hub75_le = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({evt_a.pix_valid, evt_a.line_valid, evt_a.on_valid} !== 3'b000) begin
            n_bad++; $display("FAIL reset_valids got %b want 000",
                              {evt_a.pix_valid, evt_a.line_valid, evt_a.on_valid});
        end
        n_cmp++;
        if ({evt_a.pix_col, evt_a.line_len, evt_a.on_cycles} !== 29'd0) begin
            n_bad++; $display("FAIL reset_payload got %h want 0",
                              {evt_a.pix_col, evt_a.line_len, evt_a.on_cycles});
        end
        n_cmp++;
        if ({err_ovf_a, err_addr_a} !== 2'b00) begin
            n_bad++; $display("FAIL reset_errors got %b want 00", {err_ovf_a, err_addr_a});
        end
        n_cmp++;
        if (pix_col_q.size() + line_len_q.size() + on_cyc_q.size() !== 0) begin
            n_bad++; $display("FAIL reset_no_pulse got %0d events want 0",
                              pix_col_q.size() + line_len_q.size() + on_cyc_q.size());
        end
    endtask

    task automatic test_full_line();
        clear_q();
        hub75_addr = 5'd5;
        for (int i = 0; i < 64; i++) shift_pix(6'(i));
        latch();
        n_cmp++;
        if (pix_col_q.size() !== 64) begin
            n_bad++; $display("FAIL full_pix_count got %0d want 64", pix_col_q.size());
        end
        for (int i = 0; i < 64 && i < pix_col_q.size(); i++) begin
            n_cmp++;
            if (pix_col_q[i] !== i || pix_dat_q[i] !== i) begin
                n_bad++; $display("FAIL full_pix[%0d] got col %0d data %0d want %0d",
                                  i, pix_col_q[i], pix_dat_q[i], i);
            end
        end
        n_cmp++;
        if (line_len_q.size() !== 1) begin
            n_bad++; $display("FAIL full_line_count got %0d want 1", line_len_q.size());
        end else if (line_row_q[0] !== 5 || line_len_q[0] !== 64) begin
            n_bad++; $display("FAIL full_line got row %0d len %0d want row 5 len 64",
                              line_row_q[0], line_len_q[0]);
        end
        n_cmp++;
        if ({err_ovf_a, err_addr_a} !== 2'b00) begin
            n_bad++; $display("FAIL full_errors got %b want 00", {err_ovf_a, err_addr_a});
        end
    endtask

    task automatic test_overflow();
        clear_q();
        for (int i = 0; i < 70; i++) shift_pix(6'(i));
        n_cmp++;
        if (err_ovf_a !== 1'b1) begin
            n_bad++; $display("FAIL ovf_flag_before_latch got %b want 1", err_ovf_a);
        end
        latch();
        n_cmp++;
        if (pix_col_q.size() !== 64 || pix_col_q[pix_col_q.size()-1] !== 63) begin
            n_bad++; $display("FAIL ovf_pix got count %0d want 64 ending at col 63",
                              pix_col_q.size());
        end
        n_cmp++;
        if (line_len_q.size() !== 1 || line_len_q[0] !== 64) begin
            n_bad++; $display("FAIL ovf_line_len got %0d events want one with len 64",
                              line_len_q.size());
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (err_ovf_a !== 1'b1) begin
            n_bad++; $display("FAIL ovf_sticky got %b want 1", err_ovf_a);
        end
        apply_reset();
        n_cmp++;
        if (err_ovf_a !== 1'b0) begin
            n_bad++; $display("FAIL ovf_cleared got %b want 0", err_ovf_a);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        hub75_addr = 5'd7;
        for (int i = 0; i < 9; i++) shift_pix(6'(i));
        @(negedge clk);
        hub75_data = 6'd9;
        hub75_clk  = 1'b1;
        hub75_le   = 1'b1;
        repeat (2) @(negedge clk);
        hub75_clk = 1'b0;
        hub75_le  = 1'b0;
        repeat (2) @(negedge clk);
        shift_pix(6'd33);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (pix_col_q.size() !== 11) begin
            n_bad++; $display("FAIL b2b_pix_count got %0d want 11", pix_col_q.size());
        end else begin
            n_cmp++;
            if (pix_col_q[9] !== 9 || pix_col_q[10] !== 0 || pix_dat_q[10] !== 33) begin
                n_bad++; $display("FAIL b2b_cols got %0d,%0d data %0d want 9,0 data 33",
                                  pix_col_q[9], pix_col_q[10], pix_dat_q[10]);
            end
            n_cmp++;
            if (line_cyc_q.size() !== 1 || line_cyc_q[0] !== pix_cyc_q[9]) begin
                n_bad++; $display("FAIL b2b_same_cycle got %0d line events want 1 aligned with pixel 9",
                                  line_cyc_q.size());
            end
        end
        n_cmp++;
        if (line_len_q.size() !== 1 || line_len_q[0] !== 10 || line_row_q[0] !== 7) begin
            n_bad++; $display("FAIL b2b_line got %0d events want one with len 10 row 7",
                              line_len_q.size());
        end
        latch();
    endtask

    task automatic test_on_time();
        clear_q();
        hub75_addr = 5'd3;
        repeat (4) @(negedge clk);
        hub75_blank = 1'b0;
        repeat (200) @(negedge clk);
        hub75_blank = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (on_cyc_q.size() !== 1 || on_cyc_q[0] !== 200 || on_row_q[0] !== 3) begin
            n_bad++; $display("FAIL on_full got %0d events (first cycles %0d) want one with 200 row 3",
                              on_cyc_q.size(), (on_cyc_q.size() > 0) ? on_cyc_q[0] : -1);
        end
        n_cmp++;
        if (onb_cyc_q.size() !== 1 || onb_cyc_q[0] !== 15) begin
            n_bad++; $display("FAIL on_sat_200 got %0d events want one with 15", onb_cyc_q.size());
        end
        n_cmp++;
        if ({err_addr_a, err_addr_b} !== 2'b00) begin
            n_bad++; $display("FAIL on_addr_err got %b want 00", {err_addr_a, err_addr_b});
        end
    endtask

    task automatic test_on_saturate();
        clear_q();
        hub75_addr = 5'd3;
        repeat (4) @(negedge clk);
        hub75_blank = 1'b0;
        repeat (10) @(negedge clk);
        hub75_addr = 5'd4;
        repeat (30) @(negedge clk);
        hub75_blank = 1'b1;
        repeat (6) @(negedge clk);
        hub75_addr = 5'd3;
        n_cmp++;
        if (onb_cyc_q.size() !== 1 || onb_cyc_q[0] !== 15 || onb_row_q[0] !== 3) begin
            n_bad++; $display("FAIL sat_cycles got %0d events want one with 15 row 3",
                              onb_cyc_q.size());
        end
        n_cmp++;
        if (on_cyc_q.size() !== 1 || on_cyc_q[0] !== 40) begin
            n_bad++; $display("FAIL sat_wide_cycles got %0d events want one with 40",
                              on_cyc_q.size());
        end
        n_cmp++;
        if ({err_addr_a, err_addr_b} !== 2'b11) begin
            n_bad++; $display("FAIL sat_addr_err got %b want 11", {err_addr_a, err_addr_b});
        end
    endtask

    task automatic test_reset_mid_line();
        clear_q();
        hub75_addr = 5'd9;
        for (int i = 0; i < 20; i++) shift_pix(6'(i));
        apply_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (pix_col_q.size() !== 20) begin
            n_bad++; $display("FAIL mid_pix_count got %0d want 20", pix_col_q.size());
        end
        n_cmp++;
        if (line_len_q.size() !== 0 || on_cyc_q.size() !== 0) begin
            n_bad++; $display("FAIL mid_no_pulse got %0d line %0d on want 0 0",
                              line_len_q.size(), on_cyc_q.size());
        end
        n_cmp++;
        if ({err_ovf_a, err_addr_a, err_ovf_b, err_addr_b} !== 4'b0000) begin
            n_bad++; $display("FAIL mid_errors got %b want 0000",
                              {err_ovf_a, err_addr_a, err_ovf_b, err_addr_b});
        end
        clear_q();
        for (int i = 0; i < 5; i++) shift_pix(6'(i + 40));
        latch();
        n_cmp++;
        if (line_len_q.size() !== 1 || line_len_q[0] !== 5 || line_row_q[0] !== 9) begin
            n_bad++; $display("FAIL mid_line got %0d events want one with len 5 row 9",
                              line_len_q.size());
        end
        n_cmp++;
        if (pix_col_q.size() !== 5 || pix_col_q[0] !== 0 || pix_dat_q[4] !== 44) begin
            n_bad++; $display("FAIL mid_restart_pix got %0d pixels want 5 from col 0",
                              pix_col_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_overflow();
        test_back_to_back();
        test_on_time();
        test_on_saturate();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
